input_debouncer: RTL
====================

// Module: input_debouncer
// PURPOSE
//  Conditions a raw, asynchronous, possibly bouncing 1-bit input (switch or button)
//  into a clean, synchronous level that can drive the d input of a downstream
//  D flip-flop stage. It also produces single-cycle rise/fall event pulses.
//  Structure: an N-stage synchronizer, then a stability counter and FSM, then
//  registered outputs. q/q_bar style complementary outputs are provided.
// PARAMETERS
//  SYNC_STAGES    2  synchronizer flops on d_raw; legal >= 2
//  STABLE_CYCLES  4  consecutive mismatching cycles needed to accept a new level; legal >= 1
//  RESET_LEVEL    0  value loaded into the sync chain and d_clean at reset (0 or 1)
// PORTS
//  clk        in   1  rising-edge clock, single clock domain
//  reset      in   1  synchronous, active-low reset; sampled on posedge clk only
//  d_raw      in   1  asynchronous raw input, may glitch or bounce
//  d_clean    out  1  debounced, registered level
//  d_clean_n  out  1  always ~d_clean, including during and after reset
//  rise       out  1  1-cycle pulse on the edge where d_clean goes 0->1
//  fall       out  1  1-cycle pulse on the edge where d_clean goes 1->0
//  busy       out  1  1 while a candidate level change is being counted (cnt != 0)
// BEHAVIOUR
//  - Reset (reset==0 at posedge) has priority over everything:
//    - sync chain <= RESET_LEVEL; d_clean <= RESET_LEVEL; d_clean_n <= ~RESET_LEVEL.
//    - cnt <= 0; state <= IDLE; rise, fall, busy <= 0.
//  - Synchronizer: d_sync is the last flop of the chain and lags d_raw by SYNC_STAGES edges.
//    No other logic samples d_raw.
//  - Counter: cnt has width $clog2(STABLE_CYCLES+1) and never wraps. Its max value is STABLE_CYCLES-1.
//  - FSM, two states:
//    - IDLE: entered with cnt==0.
//      - d_sync==d_clean: stay in IDLE.
//      - d_sync!=d_clean and STABLE_CYCLES==1: accept on this edge.
//      - d_sync!=d_clean otherwise: cnt <= 1 and go to COUNT.
//    - COUNT:
//      - d_sync==d_clean: the glitch is rejected. cnt <= 0 and go to IDLE. No pulse.
//      - d_sync!=d_clean and cnt==STABLE_CYCLES-1: accept on this edge.
//      - d_sync!=d_clean otherwise: cnt <= cnt+1.
//  - Accept, all on the same edge:
//    - d_clean <= d_sync and d_clean_n <= ~d_sync.
//    - cnt <= 0 and state <= IDLE.
//    - rise <= d_sync; fall <= ~d_sync.
//  - rise and fall are 1 only on the cycle after an accept edge and 0 otherwise.
//    They are never 1 together, and there is at most one pulse per accepted change.
//  - busy is registered and equals (next cnt != 0).
//  - Latency: a clean d_raw step first sampled at edge k changes d_clean at edge
//    k+SYNC_STAGES+STABLE_CYCLES-1. With the defaults, that is the 5th edge after k.
//  - A mismatch lasting fewer than STABLE_CYCLES consecutive d_sync cycles never reaches d_clean.
//  - Reset during COUNT discards the count and gives no pulse. After release, the full
//    latency applies again from the reset-loaded chain.
// TESTING  (defaults, 10-unit clock, d_raw changes mid-cycle)
//  1. reset=0 for 2 edges with d_raw=1
//     -> d_clean=0, d_clean_n=1, rise=fall=busy=0. Hold d_raw=1, release reset
//     -> d_clean=1 at the 5th edge after release, rise=1 for exactly 1 cycle.
//  2. From d_clean=1, d_raw 1->0 held
//     -> busy=1 for 3 cycles, d_clean=0 on the accept edge, fall=1 for 1 cycle, rise stays 0.
//  3. From d_clean=0, d_raw=1 for 3 cycles then back to 0
//     -> cnt reaches 3, then falls to 0; d_clean stays 0; no rise; busy returns to 0.
//  4. d_raw toggles every cycle for 20 cycles, then is held at 1
//     -> no pulse during the chatter, then exactly one rise and d_clean=1.
//  5. Reset asserted while cnt==2 with d_raw=1
//     -> cnt=0, busy=0, no rise. Release with d_raw still 1
//     -> d_clean=1 after the full 5-edge latency.
//  6. STABLE_CYCLES=1, SYNC_STAGES=3: step d_raw 0->1
//     -> d_clean=1 on edge k+3, busy never asserts, one rise pulse.

Source files
------------

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizer chain feeding a stability-counting FSM that turns a
// bouncing raw input into a clean registered level plus single-cycle rise/fall pulses.
module input_debouncer #(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_raw,
  output logic d_clean,
  output logic d_clean_n,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   d_sync_s;
  logic                   mismatch_s;
  logic                   accept_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   d_clean_r;
  logic                   d_clean_n_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   busy_r;

  assign d_sync_s   = sync_r[SYNC_STAGES-1];
  assign mismatch_s = d_sync_s ^ d_clean_r;

  // Synchronizer shift chain; the only logic that ever samples d_raw.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_raw};
    end
  end

  // Accept decode: a mismatch that has now persisted for STABLE_CYCLES samples.
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mismatch_s && (STABLE_CYCLES == 1)) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      ST_COUNT: begin
        if (mismatch_s && (cnt_r == CNT_LAST)) begin
          accept_s = 1'b1;
        end else begin
          accept_s = 1'b0;
        end
      end
      default: accept_s = 1'b0;
    endcase
  end

  // Debounce FSM with registered level, complementary level, event pulses and busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      d_clean_r   <= RESET_LEVEL;
      d_clean_n_r <= ~RESET_LEVEL;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (accept_s) begin
        d_clean_r   <= d_sync_s;
        d_clean_n_r <= ~d_sync_s;
        cnt_r       <= CNT_ZERO;
        busy_r      <= 1'b0;
        state_r     <= ST_IDLE;
        rise_r      <= d_sync_s;
        fall_r      <= ~d_sync_s;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (mismatch_s) begin
              cnt_r   <= CNT_ONE;
              busy_r  <= 1'b1;
              state_r <= ST_COUNT;
            end else begin
              cnt_r   <= CNT_ZERO;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
          ST_COUNT: begin
            if (mismatch_s) begin
              cnt_r   <= cnt_r + CNT_ONE;
              busy_r  <= 1'b1;
              state_r <= ST_COUNT;
            end else begin
              // Level went back before it was stable long enough: drop it silently.
              cnt_r   <= CNT_ZERO;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end
          end
          default: begin
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign d_clean   = d_clean_r;
  assign d_clean_n = d_clean_n_r;
  assign rise      = rise_r;
  assign fall      = fall_r;
  assign busy      = busy_r;

  input_debouncer_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .d_clean   (d_clean_r),
    .d_clean_n (d_clean_n_r),
    .rise      (rise_r),
    .fall      (fall_r),
    .busy      (busy_r),
    .cnt_nz    (|cnt_r)
  );

endmodule

// input_debouncer_chk: structural invariants of the debouncer outputs.
module input_debouncer_chk (
  input logic clk,
  input logic reset,
  input logic d_clean,
  input logic d_clean_n,
  input logic rise,
  input logic fall,
  input logic busy,
  input logic cnt_nz
);

  a_complement : assert property (@(posedge clk) disable iff (!reset) d_clean_n == ~d_clean);
  a_one_pulse  : assert property (@(posedge clk) disable iff (!reset) !(rise && fall));
  a_busy_cnt   : assert property (@(posedge clk) disable iff (!reset) busy == cnt_nz);

endmodule
